hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Parametrised forwarding/stall controller for the CPU integer pipeline. Tracks destination info of every in-flight
//  instr from EX to the last forwarding stage, muxes bypass data onto both EX operands, and issues load-use stalls
//  sized to the configured load latency. Also handles branch-flush bubbles, halt freeze, and a saturating stall counter.
// PARAMETERS
//  XLEN        32  data width of forwarded operands
//  RA_W        5   register-address width
//  N_FWD       2   forwarding source stages after EX (1=MEM .. N_FWD=WB); >=1
//  LOAD_STAGE  2   first stage index (1..N_FWD) where load data is valid on fwd_data
//  CNT_W       16  stall counter width
// PORTS
//  clk           in   1            core clock
//  rst           in   1            asynchronous active-high reset
//  halted        in   1            freeze all state (pipeline halted)
//  flush         in   1            squash instr in decode; EX receives a bubble next cycle
//  dec_rs1       in   RA_W         decode source reg 1
//  dec_rs2       in   RA_W         decode source reg 2
//  dec_rs1_used  in   1            decode instr reads rs1
//  dec_rs2_used  in   1            decode instr reads rs2
//  dec_rd        in   RA_W         decode destination reg
//  dec_wr        in   1            decode instr writes rd (0 for SW/BT/BF/EBREAK)
//  dec_is_load   in   1            decode instr's rd value comes late (LW)
//  fwd_data      in   N_FWD*XLEN   result of stage k at bits [k*XLEN-1 -: XLEN], k=1..N_FWD
//  hazard1       out  1            forward_data1 replaces regfile operand 1
//  hazard2       out  1            forward_data2 replaces regfile operand 2
//  forward_data1 out  XLEN         bypass value for EX operand 1, 0 when hazard1=0
//  forward_data2 out  XLEN         bypass value for EX operand 2, 0 when hazard2=0
//  stall         out  1            hold fetch/decode this cycle
//  stall_count   out  CNT_W        saturating count of stalled, non-halted cycles
// BEHAVIOUR
//  - Entry = {valid, rd, wr, is_load}. Entries e[0..N_FWD]: e[0] = EX, e[k] = stage k. Also ex_rs1/ex_rs2 regs.
//  - Reset (async): all entries valid=0, ex_rs*=0, stall_count=0; hence hazard*=0, forward_data*=0, stall=0.
//  - Per clk edge, halted=1: no state changes, stall_count holds.
//  - Per clk edge, halted=0: e[k]<=e[k-1] (k>=1). If stall|flush: e[0]<=bubble (valid=0), ex_rs*<=0;
//    else e[0]<={1,dec_rd,dec_wr,dec_is_load}, ex_rs1<=dec_rs1&{RA_W{dec_rs1_used}}, same for rs2.
//  - Forward (comb, per operand j): scan k=1..N_FWD ascending; first e[k] with valid&wr&rd!=0&rd==ex_rsj wins
//    (youngest wins) -> hazardj=1, forward_dataj=fwd_data[k]. x0 never forwarded.
//  - Stall (comb): 1 iff !flush and some used dec_rsj!=0 matches e[k].rd with valid&wr&is_load, k in 0..LOAD_STAGE-2.
//    Next cycle it reaches k+1<LOAD_STAGE, data not yet valid; 1-cycle bubble for LOAD_STAGE=2, auto-repeats for deeper.
//  - flush beats stall: stall=0 while flush=1. Stall output is combinational also while halted (state is frozen).
//  - A winning match with is_load & k<LOAD_STAGE is a protocol violation (stall must prevent it); SVA assertion, no recovery.
//  - stall_count increments when stall&!halted; saturates at all-ones.
//  - Zero cycle latency on all outputs; outputs depend on current state + decode inputs only.
// STRUCTURE
//  - hazard_pkg: typedef struct packed pipe_entry_t {valid, rd, wr, is_load}; BUBBLE constant; opcode localparams
//    used by decode to drive dec_wr/dec_is_load.
//  - Sub-module hazard_fwd_mux (one operand: priority scan over e[1..N_FWD]), instantiated twice.
//  - Top owns entry shift register, ex_rs regs, stall logic, stall counter.
// TESTING (defaults unless noted)
//  - ADDI x5 then ADD x6,x5,x5: cycle ADD in EX -> hazard1=hazard2=1, forward_data*=fwd_data[1]; stall=0.
//  - x5 written by instrs 1 and 2 back-to-back, then read: youngest (k=1) value forwarded, not k=2.
//  - LW x7 then ADD x8,x7,x1: stall=1 exactly one cycle, bubble enters EX; ADD then forwards fwd_data[2], hazard2=0.
//  - LOAD_STAGE=3,N_FWD=3: LW x7 then use -> stall held 2 cycles, stall_count +2, forward from k=3.
//  - LW x7 followed by use with flush=1 same cycle -> stall=0, EX gets bubble; halted=1 for 5 cycles mid-stall ->
//    entries and stall_count unchanged; rst pulse mid-run -> all outputs 0 immediately (async).
//  - SW/BT to x3 (dec_wr=0) and writes to x0 followed by reads of x3/x0 -> hazard*=0, stall=0.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the integer-pipeline forwarding/stall controller: pipeline entry record,
// bubble constant, and the opcode classes decode uses to drive dec_wr / dec_is_load.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef struct packed {
        logic                valid;
        logic [RegAddrW-1:0] rd;
        logic                wr;
        logic                is_load;
    } pipe_entry_t;

    localparam pipe_entry_t Bubble = '0;

    localparam logic [2:0] OpAlu     = 3'd0;
    localparam logic [2:0] OpAluImm  = 3'd1;
    localparam logic [2:0] OpLoad    = 3'd2;
    localparam logic [2:0] OpStore   = 3'd3;
    localparam logic [2:0] OpBranchT = 3'd4;
    localparam logic [2:0] OpBranchF = 3'd5;
    localparam logic [2:0] OpEbreak  = 3'd6;

    function automatic logic op_writes_rd(input logic [2:0] op);
        return op inside {OpAlu, OpAluImm, OpLoad};
    endfunction

    function automatic logic op_is_load(input logic [2:0] op);
        return op == OpLoad;
    endfunction

    // x0 is hard-wired, so it never creates a dependency.
    function automatic logic src_hit(input logic [RegAddrW-1:0] rd, input logic [RegAddrW-1:0] rs,
                                     input logic used);
        return used && (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode/bypass bundle between the pipeline (master) and the forwarding controller (slave).
interface hazard_fwd_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned N_FWD = 2,
    parameter int unsigned CNT_W = 16
);
    logic                    halted;
    logic                    flush;
    logic [RA_W-1:0]         dec_rs1;
    logic [RA_W-1:0]         dec_rs2;
    logic                    dec_rs1_used;
    logic                    dec_rs2_used;
    logic [RA_W-1:0]         dec_rd;
    logic                    dec_wr;
    logic                    dec_is_load;
    logic [N_FWD*XLEN-1:0]   fwd_data;
    logic                    hazard1;
    logic                    hazard2;
    logic [XLEN-1:0]         forward_data1;
    logic [XLEN-1:0]         forward_data2;
    logic                    stall;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output halted, flush, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr,
               dec_is_load, fwd_data,
        input  hazard1, hazard2, forward_data1, forward_data2, stall, stall_count
    );

    modport slave (
        input  halted, flush, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr,
               dec_is_load, fwd_data,
        output hazard1, hazard2, forward_data1, forward_data2, stall, stall_count
    );

endinterface

// File: rtl/hazard_fwd_ctrl_mux.sv
// Bypass select for one EX operand: priority scan over stages 1..N_FWD, youngest match wins.
module hazard_fwd_ctrl_mux
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned N_FWD      = 2,
    parameter int unsigned LOAD_STAGE = 2
) (
    input  pipe_entry_t [N_FWD:1]    ents,
    input  logic [RegAddrW-1:0]      rs,
    input  logic [N_FWD*XLEN-1:0]    fwd_data,
    output logic                     hit,
    output logic [XLEN-1:0]          data,
    output logic                     late_load
);

    // Scan oldest to youngest so the youngest matching stage overwrites the rest.
    always_comb begin
        hit       = 1'b0;
        data      = '0;
        late_load = 1'b0;
        for (int k = N_FWD; k >= 1; k--) begin
            if (ents[k].valid && ents[k].wr && src_hit(ents[k].rd, rs, 1'b1)) begin
                hit       = 1'b1;
                data      = fwd_data[k*XLEN-1 -: XLEN];
                late_load = ents[k].is_load && (k < int'(LOAD_STAGE));
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding/stall controller: in-flight destination tracking, operand bypass, load-use stall,
// branch-flush bubbles, halt freeze and a saturating stall counter.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RA_W       = RegAddrW,
    parameter int unsigned N_FWD      = 2,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave bus
);

    if (RA_W != RegAddrW || N_FWD < 1 || LOAD_STAGE < 1 || LOAD_STAGE > N_FWD) begin : g_param_check
        $error("hazard_fwd_ctrl: unsupported parameter combination");
    end

    pipe_entry_t [N_FWD:0] ents_q;
    logic [RA_W-1:0]       ex_rs1_q;
    logic [RA_W-1:0]       ex_rs2_q;
    logic [CNT_W-1:0]      stall_count_q;
    logic                  load_hit;
    logic                  stall;
    logic                  late1;
    logic                  late2;

    // A load still younger than LOAD_STAGE-1 cannot supply its value when the consumer reaches EX.
    always_comb begin
        load_hit = 1'b0;
        for (int k = 0; k < int'(LOAD_STAGE) - 1; k++) begin
            if (ents_q[k].valid && ents_q[k].wr && ents_q[k].is_load &&
                (src_hit(ents_q[k].rd, bus.dec_rs1, bus.dec_rs1_used) ||
                 src_hit(ents_q[k].rd, bus.dec_rs2, bus.dec_rs2_used))) begin
                load_hit = 1'b1;
            end
        end
    end

    assign stall           = load_hit && !bus.flush;
    assign bus.stall       = stall;
    assign bus.stall_count = stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ents_q        <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            stall_count_q <= '0;
        end else if (!bus.halted) begin
            for (int k = 1; k <= int'(N_FWD); k++) begin
                ents_q[k] <= ents_q[k-1];
            end
            if (stall || bus.flush) begin
                ents_q[0] <= Bubble;
                ex_rs1_q  <= '0;
                ex_rs2_q  <= '0;
            end else begin
                ents_q[0] <= '{valid: 1'b1, rd: bus.dec_rd, wr: bus.dec_wr, is_load: bus.dec_is_load};
                ex_rs1_q  <= bus.dec_rs1 & {RA_W{bus.dec_rs1_used}};
                ex_rs2_q  <= bus.dec_rs2 & {RA_W{bus.dec_rs2_used}};
            end
            if (stall && stall_count_q != '1) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    hazard_fwd_ctrl_mux #(
        .XLEN      (XLEN),
        .N_FWD     (N_FWD),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_mux1 (
        .ents     (ents_q[N_FWD:1]),
        .rs       (ex_rs1_q),
        .fwd_data (bus.fwd_data),
        .hit      (bus.hazard1),
        .data     (bus.forward_data1),
        .late_load(late1)
    );

    hazard_fwd_ctrl_mux #(
        .XLEN      (XLEN),
        .N_FWD     (N_FWD),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_mux2 (
        .ents     (ents_q[N_FWD:1]),
        .rs       (ex_rs2_q),
        .fwd_data (bus.fwd_data),
        .hit      (bus.hazard2),
        .data     (bus.forward_data2),
        .late_load(late2)
    );

    // The stall must keep a consumer away from a load whose data is not yet on fwd_data.
    a_no_late_load: assert property (@(posedge clk) disable iff (rst) !(late1 || late2));

endmodule
